regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the next multicycle/pipelined CPU datapath. It replaces the fixed 32×32, 2-read/1-write register file with the following:
- configurable width, depth and read-port count;
- two prioritised write ports;
- optional same-cycle write-to-read bypass;
- a hardwired zero register;
- a sequenced soft-clear engine that sweeps one entry per cycle, so the array can map to distributed RAM.

It sits between the decode/writeback stages and the ALU operand latches; the debug port feeds the board display.

---
 rtl/regfile_pkg.sv | 38 +++
 rtl/regfile_rd_port.sv | 40 ++++
 rtl/regfile_mp.sv | 148 ++++++++++++++
 tb/tb_regfile_mp.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The slice macros keep the packed read-port indexing readable at call sites.

`define RF_SLICE(vec, k, w) vec[(k)*(w) +: (w)]

package regfile_pkg;

  // Sweep controller states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Default geometry of the datapath register file.
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  // Number of entries addressed by an addr_w-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Ceiling log2; clog2(1) is taken as 1 so that derived widths never collapse to 0.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    if (bits == 0) begin
      bits = 1;
    end else begin
      bits = bits;
    end
    return bits;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read mux: blanking, hardwired zero entry and optional
// same-cycle bypass from the two write ports (port 1 has priority).

module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [depth_of(ADDR_W)*DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               blank,
  input  logic                               wen0,
  input  logic [ADDR_W-1:0]                  waddr0,
  input  logic [DATA_W-1:0]                  wdata0,
  input  logic                               wen1,
  input  logic [ADDR_W-1:0]                  waddr1,
  input  logic [DATA_W-1:0]                  wdata1,
  output logic [DATA_W-1:0]                  data
);

  // Select stored word, then override with zero or bypassed write data.
  always_comb begin
    data = mem[int'(addr)*DATA_W +: DATA_W];
    if (blank) begin
      data = {DATA_W{1'b0}};
    end else if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
      data = {DATA_W{1'b0}};
    end else if ((BYPASS != 0) && wen1 && (waddr1 == addr)) begin
      data = wdata1;
    end else if ((BYPASS != 0) && wen0 && (waddr0 == addr)) begin
      data = wdata0;
    end else begin
      data = mem[int'(addr)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NRD read ports, two prioritised write ports,
// hardwired zero entry, and a one-entry-per-cycle soft-clear sweep.

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic                    wen0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    wen1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic [NRD*ADDR_W-1:0]   raddr,
  output logic [NRD*DATA_W-1:0]   rdata,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data,
  output logic                    wr_conflict,
  output logic                    wr_drop
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int PTR_W = clog2(DEPTH);

  state_t                   state_r;
  logic [PTR_W-1:0]         clr_ptr_r;
  logic [DATA_W-1:0]        mem_r [DEPTH];
  logic [DEPTH*DATA_W-1:0]  mem_flat_s;
  logic                     eff0_s;
  logic                     eff1_s;
  logic                     blank_s;

  // A write to the zero entry is not a real write: it never commits or flags.
  assign eff0_s  = wen0 & ~((ZERO_REG != 0) & (waddr0 == {ADDR_W{1'b0}}));
  assign eff1_s  = wen1 & ~((ZERO_REG != 0) & (waddr1 == {ADDR_W{1'b0}}));
  // Reads show zero while the sweep runs and while reset is held.
  assign blank_s = busy | rst;

  // Sweep controller with registered busy and offence flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      clr_ptr_r   <= {PTR_W{1'b0}};
      busy        <= 1'b0;
      wr_conflict <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wr_drop     <= 1'b0;
          wr_conflict <= eff0_s & eff1_s & (waddr0 == waddr1);
          if (clr_req) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {PTR_W{1'b0}};
            busy      <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          wr_conflict <= 1'b0;
          wr_drop     <= eff0_s | eff1_s;
          clr_ptr_r   <= clr_ptr_r + PTR_W'(1);
          if (clr_ptr_r == {PTR_W{1'b1}}) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          clr_ptr_r   <= {PTR_W{1'b0}};
          busy        <= 1'b0;
          wr_conflict <= 1'b0;
          wr_drop     <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep clears one entry per edge; otherwise port 1 lands last and wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[clr_ptr_r] <= {DATA_W{1'b0}};
    end else begin
      if (eff0_s) begin
        mem_r[waddr0] <= wdata0;
      end
      if (eff1_s) begin
        mem_r[waddr1] <= wdata1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat_s[g*DATA_W +: DATA_W] = mem_r[g];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .mem    (mem_flat_s),
      .addr   (`RF_SLICE(raddr, k, ADDR_W)),
      .blank  (blank_s),
      .wen0   (eff0_s),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .wen1   (eff1_s),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .data   (`RF_SLICE(rdata, k, DATA_W))
    );
  end

  // The debug view shows stored contents only, never in-flight write data.
  regfile_rd_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0), .ZERO_REG(ZERO_REG)
  ) u_dbg (
    .mem    (mem_flat_s),
    .addr   (dbg_addr),
    .blank  (blank_s),
    .wen0   (eff0_s),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .wen1   (eff1_s),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .data   (dbg_data)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three instances (bypass, no bypass, small 16x8 with
// four read ports), a behavioural model checked every cycle, plus directed
// literal expectations.

module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus shared by instances A (BYPASS=1) and B (BYPASS=0).
  logic        clr_req, wen0, wen1;
  logic [4:0]  waddr0, waddr1, dbg_addr;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic [31:0] dbg_a, dbg_b;
  logic        busy_a, busy_b, conf_a, conf_b, drop_a, drop_b;

  // Stimulus for instance C (DATA_W=16, ADDR_W=3, NRD=4).
  logic        c_clr, c_wen0, c_wen1;
  logic [2:0]  c_wa0, c_wa1, c_dbg;
  logic [15:0] c_wd0, c_wd1;
  logic [11:0] c_raddr;
  logic [63:0] c_rdata;
  logic [15:0] c_dbgd;
  logic        c_busy, c_conf, c_drop;

  int total  = 0;
  int passed = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a),
    .wr_conflict(conf_a), .wr_drop(drop_a));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b),
    .wr_conflict(conf_b), .wr_drop(drop_b));

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4), .BYPASS(1), .ZERO_REG(1)) u_c (
    .clk(clk), .rst(rst), .clr_req(c_clr), .busy(c_busy),
    .wen0(c_wen0), .waddr0(c_wa0), .wdata0(c_wd0),
    .wen1(c_wen1), .waddr1(c_wa1), .wdata1(c_wd1),
    .raddr(c_raddr), .rdata(c_rdata), .dbg_addr(c_dbg), .dbg_data(c_dbgd),
    .wr_conflict(c_conf), .wr_drop(c_drop));

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        clr;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
  } in_t;

  in_t         in_s [2];
  logic [31:0] m_mem [2][32];
  logic        m_busy [2];
  logic        m_conf [2];
  logic        m_drop [2];
  int          m_left [2];

  // Collect each model slot's inputs in a common widened form.
  always_comb begin
    in_s[0] = {clr_req, wen0, waddr0, wdata0, wen1, waddr1, wdata1};
    in_s[1] = {c_clr, c_wen0, {2'b00, c_wa0}, {16'h0000, c_wd0},
               c_wen1, {2'b00, c_wa1}, {16'h0000, c_wd1}};
  end

  function automatic int depth_of(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic logic eff(input int i, input int p);
    if (p == 0) return in_s[i].we0 && (in_s[i].wa0 != 5'd0);
    return in_s[i].we1 && (in_s[i].wa1 != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a, input bit byp);
    if (rst || m_busy[i] || (a == 5'd0)) return 32'd0;
    if (byp && eff(i, 1) && (in_s[i].wa1 == a)) return in_s[i].wd1;
    if (byp && eff(i, 0) && (in_s[i].wa0 == a)) return in_s[i].wd0;
    return m_mem[i][a];
  endfunction

  // Model: a clear request makes the file busy for DEPTH edges, then empty.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int a = 0; a < 32; a++) m_mem[i][a] <= 32'd0;
        m_busy[i] <= 1'b0;
        m_left[i] <= 0;
        m_conf[i] <= 1'b0;
        m_drop[i] <= 1'b0;
      end else begin
        m_conf[i] <= !m_busy[i] && eff(i, 0) && eff(i, 1) && (in_s[i].wa0 == in_s[i].wa1);
        m_drop[i] <= m_busy[i] && (eff(i, 0) || eff(i, 1));
        if (!m_busy[i]) begin
          if (eff(i, 0)) m_mem[i][in_s[i].wa0] <= in_s[i].wd0;
          if (eff(i, 1)) m_mem[i][in_s[i].wa1] <= in_s[i].wd1;
          if (in_s[i].clr) begin
            m_busy[i] <= 1'b1;
            m_left[i] <= depth_of(i);
          end
        end else if (m_left[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_left[i] <= 0;
          for (int a = 0; a < 32; a++) m_mem[i][a] <= 32'd0;
        end else begin
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Compare every output of every instance against the model, away from the edge.
  always @(negedge clk) begin
    chk("a_busy", 64'(busy_a), 64'(m_busy[0]));
    chk("b_busy", 64'(busy_b), 64'(m_busy[0]));
    chk("c_busy", 64'(c_busy), 64'(m_busy[1]));
    chk("a_conflict", 64'(conf_a), 64'(m_conf[0]));
    chk("b_conflict", 64'(conf_b), 64'(m_conf[0]));
    chk("c_conflict", 64'(c_conf), 64'(m_conf[1]));
    chk("a_drop", 64'(drop_a), 64'(m_drop[0]));
    chk("b_drop", 64'(drop_b), 64'(m_drop[0]));
    chk("c_drop", 64'(c_drop), 64'(m_drop[1]));
    for (int k = 0; k < 2; k++) begin
      chk("a_rdata", 64'(rdata_a[k*32 +: 32]), 64'(exp_rd(0, raddr[k*5 +: 5], 1'b1)));
      chk("b_rdata", 64'(rdata_b[k*32 +: 32]), 64'(exp_rd(0, raddr[k*5 +: 5], 1'b0)));
    end
    for (int k = 0; k < 4; k++) begin
      chk("c_rdata", 64'(c_rdata[k*16 +: 16]), 64'(exp_rd(1, 5'(c_raddr[k*3 +: 3]), 1'b1)));
    end
    chk("a_dbg", 64'(dbg_a), 64'(exp_rd(0, dbg_addr, 1'b0)));
    chk("b_dbg", 64'(dbg_b), 64'(exp_rd(0, dbg_addr, 1'b0)));
    chk("c_dbg", 64'(c_dbgd), 64'(exp_rd(1, 5'(c_dbg), 1'b0)));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input bit use_c, output int n);
    n = 0;
    while ((use_c ? c_busy : busy_a) && (n < 200)) begin
      step();
      n = n + 1;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1;
    clr_req = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    waddr0 = 5'd0; waddr1 = 5'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    raddr = 10'd0; dbg_addr = 5'd0;
    c_clr = 1'b0; c_wen0 = 1'b0; c_wen1 = 1'b0;
    c_wa0 = 3'd0; c_wa1 = 3'd0; c_wd0 = 16'd0; c_wd1 = 16'd0;
    c_raddr = 12'd0; c_dbg = 3'd0;

    // Write attempted during reset must not stick.
    #1;
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr = {5'd5, 5'd5}; dbg_addr = 5'd5;
    step(); step();
    chk("rst_rdata", rdata_a, 64'd0);
    wen0 = 1'b0;
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)}; dbg_addr = 5'(a);
      step();
      chk("post_rst_rdata_a", rdata_a, 64'd0);
      chk("post_rst_dbg_b", 64'(dbg_b), 64'd0);
    end
    chk("post_rst_busy", 64'(busy_a), 64'd0);

    // Both ports to r7: port 1 wins, one-cycle conflict.
    wen0 = 1'b1; wen1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7;
    wdata0 = 32'h11; wdata1 = 32'h22; raddr = {5'd7, 5'd7}; dbg_addr = 5'd7;
    #1;
    chk("bypass_prio_a", 64'(rdata_a[31:0]), 64'h22);
    chk("nobypass_old_b", 64'(rdata_b[31:0]), 64'h0);
    step();
    wen0 = 1'b0; wen1 = 1'b0;
    #1;
    chk("conflict_high", 64'(conf_a), 64'd1);
    chk("prio_r7_b", 64'(rdata_b[31:0]), 64'h22);
    step();
    chk("conflict_one_cycle", 64'(conf_a), 64'd0);

    // Same to r0: ignored, no conflict.
    wen0 = 1'b1; wen1 = 1'b1; waddr0 = 5'd0; waddr1 = 5'd0; raddr = {5'd0, 5'd0};
    #1;
    chk("r0_bypass_zero", rdata_a, 64'd0);
    step();
    wen0 = 1'b0; wen1 = 1'b0;
    #1;
    chk("r0_no_conflict", 64'(conf_a), 64'd0);
    chk("r0_stays_zero", rdata_b, 64'd0);

    // Bypass of 0xCAFE to r3.
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hCAFE; raddr = {5'd7, 5'd3};
    #1;
    chk("bypass_same_cycle", 64'(rdata_a[31:0]), 64'hCAFE);
    chk("nobypass_same_cycle", 64'(rdata_b[31:0]), 64'h0);
    step();
    wen0 = 1'b0;
    #1;
    chk("nobypass_next_cycle", 64'(rdata_b[31:0]), 64'hCAFE);

    // Fill r1..r31 with their index, alternating write ports.
    for (int i = 1; i < 32; i++) begin
      wen0 = (i % 2 == 1); wen1 = (i % 2 == 0);
      waddr0 = 5'(i); waddr1 = 5'(i); wdata0 = 32'(i); wdata1 = 32'(i);
      step();
    end
    wen0 = 1'b0; wen1 = 1'b0;
    raddr = {5'd31, 5'd1}; dbg_addr = 5'd17;
    #1;
    chk("fill_read", rdata_b, {32'd31, 32'd1});
    chk("fill_dbg", 64'(dbg_a), 64'd17);

    // Soft clear with a dropped write in clear cycle 10.
    clr_req = 1'b1; raddr = {5'd9, 5'd1};
    step();
    clr_req = 1'b0;
    n = 0;
    while (busy_a && (n < 200)) begin
      if (n == 9) begin
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h9999;
      end else begin
        wen1 = 1'b0;
      end
      step();
      n = n + 1;
      if (n == 5) chk("clear_reads_zero", rdata_a, 64'd0);
      if (n == 10) chk("drop_pulse", 64'(drop_a), 64'd1);
      if (n == 11) chk("drop_once", 64'(drop_a), 64'd0);
    end
    wen1 = 1'b0;
    chk("clear_len_32", 64'(n), 64'd32);
    #1;
    chk("r9_after_clear", rdata_b, 64'd0);

    // Reset in clear cycle 12.
    wen0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
    wen1 = 1'b1; waddr1 = 5'd20; wdata1 = 32'h2020;
    step();
    wen0 = 1'b0; wen1 = 1'b0; raddr = {5'd20, 5'd4};
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 11; i++) step();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_clear_busy", 64'(busy_a), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_clear_mem", rdata_b, 64'd0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    count_busy(1'b0, n);
    chk("clear_after_rst_len", 64'(n), 64'd32);

    // Small instance: four distinct reads, then an 8-cycle clear.
    c_wen0 = 1'b1; c_wa0 = 3'd1; c_wd0 = 16'h1111;
    c_wen1 = 1'b1; c_wa1 = 3'd2; c_wd1 = 16'h2222;
    step();
    c_wa0 = 3'd5; c_wd0 = 16'h5555; c_wa1 = 3'd6; c_wd1 = 16'h6666;
    step();
    c_wen0 = 1'b0; c_wen1 = 1'b0;
    c_raddr = {3'd6, 3'd5, 3'd2, 3'd1}; c_dbg = 3'd6;
    #1;
    chk("c_four_reads", c_rdata, 64'h6666_5555_2222_1111);
    chk("c_dbg_read", 64'(c_dbgd), 64'h6666);
    c_clr = 1'b1;
    step();
    c_clr = 1'b0;
    count_busy(1'b1, n);
    chk("c_clear_len_8", 64'(n), 64'd8);
    #1;
    chk("c_after_clear", c_rdata, 64'd0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
